// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA raster timing generator and the memory/display stage.
// The generator takes the master side; the image memory stage takes the slave side.
interface vga_timing_gen_if;
  logic        i_enable;
  logic [18:0] o_vga_addr;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_blank_n;
  logic        o_frame_start;

  modport master (
    input  i_enable,
    output o_vga_addr,
    output o_hsync,
    output o_vsync,
    output o_blank_n,
    output o_frame_start
  );

  modport slave (
    output i_enable,
    input  o_vga_addr,
    input  o_hsync,
    input  o_vsync,
    input  o_blank_n,
    input  o_frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, undelayed linear frame-buffer
// address, and sync/blank/frame strobes delayed PIPE_DLY cycles to match RGB latency.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 3
) (
  input  logic i_vga_clk,
  input  logic rstn,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [H_W-1:0] HS_FIRST   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0] VS_FIRST   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Strobe bit positions inside each delay stage.
  localparam int S_HS = 0;
  localparam int S_VS = 1;
  localparam int S_BN = 2;
  localparam int S_FS = 3;

  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic [18:0]    addr_q, addr_d;

  logic [PIPE_DLY-1:0][3:0] pipe_q, pipe_d;

  logic h_last, v_last, h_act, v_act;
  logic [3:0] raw;

  always_comb begin
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
    h_act  = (h_cnt_q <= H_ACT_LAST);
    v_act  = (v_cnt_q <= V_ACT_LAST);

    // Raw strobes are gated by the live enable so a disabled raster parked at
    // (0,0) never emits a frame-start or active-video indication.
    raw       = '0;
    raw[S_HS] = vga.i_enable & (h_cnt_q >= HS_FIRST) & (h_cnt_q <= HS_LAST);
    raw[S_VS] = vga.i_enable & (v_cnt_q >= VS_FIRST) & (v_cnt_q <= VS_LAST);
    raw[S_BN] = vga.i_enable & h_act & v_act;
    raw[S_FS] = vga.i_enable & (h_cnt_q == '0) & (v_cnt_q == '0);

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    addr_d  = addr_q;

    if (!vga.i_enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      addr_d  = '0;
    end else begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + V_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
      end

      if (h_last && v_last) begin
        addr_d = '0;
      end else if (h_act && v_act) begin
        addr_d = addr_q + 19'd1;
      end
    end

    pipe_d    = '0;
    pipe_d[0] = raw;
    for (int unsigned i = 1; i < PIPE_DLY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge i_vga_clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      pipe_q  <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
      pipe_q  <= pipe_d;
    end
  end

  // Syncs are carried active-high internally; polarity is applied at the pins so
  // cleared delay stages present the deasserted level.
  assign vga.o_vga_addr    = addr_q;
  assign vga.o_hsync       = pipe_q[PIPE_DLY-1][S_HS] ~^ SYNC_POL;
  assign vga.o_vsync       = pipe_q[PIPE_DLY-1][S_VS] ~^ SYNC_POL;
  assign vga.o_blank_n     = pipe_q[PIPE_DLY-1][S_BN];
  assign vga.o_frame_start = pipe_q[PIPE_DLY-1][S_FS];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line-level
// timing and a tiny raster instance (active-high syncs, 2-stage delay) for frame-level timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  vga_timing_gen_if vif_def ();
  vga_timing_gen_if vif_sm ();

  vga_timing_gen dut_def (
    .i_vga_clk (clk),
    .rstn      (rstn),
    .vga       (vif_def)
  );

  // 15 clocks/line (8+2+3+2), 10 lines/frame (6+1+2+1), 150 clocks/frame.
  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .SYNC_POL (1'b1),
    .PIPE_DLY (2)
  ) dut_sm (
    .i_vga_clk (clk),
    .rstn      (rstn),
    .vga       (vif_sm)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_en(input logic v);
    vif_def.i_enable = v;
    vif_sm.i_enable  = v;
  endtask

  initial begin
    int blank_hi;
    int hs_lo;
    int sm_vs_hi;
    blank_hi = 0;
    hs_lo    = 0;
    sm_vs_hi = 0;

    rstn = 1'b0;
    set_en(1'b1);
    repeat (3) @(negedge clk);

    chk("rst def addr",  vif_def.o_vga_addr, 0);
    chk("rst def hsync", vif_def.o_hsync, 1);
    chk("rst def vsync", vif_def.o_vsync, 1);
    chk("rst def blank", vif_def.o_blank_n, 0);
    chk("rst def fs",    vif_def.o_frame_start, 0);
    chk("rst sm hsync",  vif_sm.o_hsync, 0);
    chk("rst sm vsync",  vif_sm.o_vsync, 0);
    chk("rst sm addr",   vif_sm.o_vga_addr, 0);

    rstn = 1'b1;

    // k = number of rising edges since reset release; raster shows pixel k.
    for (int k = 0; k <= 1700; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 800) begin
        blank_hi += int'(vif_def.o_blank_n);
        hs_lo    += int'(!vif_def.o_hsync);
      end
      if (k < 150) sm_vs_hi += int'(vif_sm.o_vsync);

      case (k)
        0:    chk("def addr (0,0)", vif_def.o_vga_addr, 0);
        1:    chk("sm fs k1", vif_sm.o_frame_start, 0);
        2: begin
          chk("def fs k2", vif_def.o_frame_start, 0);
          chk("def blank k2", vif_def.o_blank_n, 0);
          chk("sm fs k2", vif_sm.o_frame_start, 1);
        end
        3: begin
          chk("def fs k3", vif_def.o_frame_start, 1);
          chk("def blank k3", vif_def.o_blank_n, 1);
          chk("sm fs k3", vif_sm.o_frame_start, 0);
        end
        4:    chk("def fs k4", vif_def.o_frame_start, 0);
        11:   chk("sm hsync k11", vif_sm.o_hsync, 0);
        12:   chk("sm hsync k12", vif_sm.o_hsync, 1);
        14:   chk("sm hsync k14", vif_sm.o_hsync, 1);
        15:   chk("sm hsync k15", vif_sm.o_hsync, 0);
        82:   chk("sm addr last active", vif_sm.o_vga_addr, 47);
        83:   chk("sm addr vblank", vif_sm.o_vga_addr, 48);
        84:   chk("sm blank k84", vif_sm.o_blank_n, 1);
        85:   chk("sm blank k85", vif_sm.o_blank_n, 0);
        92:   chk("sm blank vblank", vif_sm.o_blank_n, 0);
        106:  chk("sm vsync k106", vif_sm.o_vsync, 0);
        107:  chk("sm vsync k107", vif_sm.o_vsync, 1);
        136:  chk("sm vsync k136", vif_sm.o_vsync, 1);
        137:  chk("sm vsync k137", vif_sm.o_vsync, 0);
        149:  chk("sm addr frame end", vif_sm.o_vga_addr, 48);
        150:  chk("sm addr wrap", vif_sm.o_vga_addr, 0);
        151: begin
          chk("sm addr k151", vif_sm.o_vga_addr, 1);
          chk("sm fs k151", vif_sm.o_frame_start, 0);
        end
        152:  chk("sm fs 2nd frame", vif_sm.o_frame_start, 1);
        153:  chk("sm fs k153", vif_sm.o_frame_start, 0);
        639:  chk("def addr (639,0)", vif_def.o_vga_addr, 639);
        640:  chk("def addr (640,0)", vif_def.o_vga_addr, 640);
        642:  chk("def blank k642", vif_def.o_blank_n, 1);
        643:  chk("def blank k643", vif_def.o_blank_n, 0);
        658:  chk("def hsync k658", vif_def.o_hsync, 1);
        659:  chk("def hsync k659", vif_def.o_hsync, 0);
        754:  chk("def hsync k754", vif_def.o_hsync, 0);
        755:  chk("def hsync k755", vif_def.o_hsync, 1);
        799:  chk("def addr (799,0)", vif_def.o_vga_addr, 640);
        800:  chk("def addr (0,1)", vif_def.o_vga_addr, 640);
        801:  chk("def addr (1,1)", vif_def.o_vga_addr, 641);
        802:  chk("def blank k802", vif_def.o_blank_n, 0);
        803: begin
          chk("def blank k803", vif_def.o_blank_n, 1);
          chk("def fs line1", vif_def.o_frame_start, 0);
        end
        1700: begin
          chk("def addr (100,2)", vif_def.o_vga_addr, 1380);
          chk("sm addr (5,3)", vif_sm.o_vga_addr, 29);
        end
        default: ;
      endcase
    end

    chk("def blank high count", blank_hi, 640);
    chk("def hsync low count", hs_lo, 96);
    chk("sm vsync high count", sm_vs_hi, 30);

    // Enable drop at pixel (100,2).
    set_en(1'b0);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      case (j)
        1: begin
          chk("dis def addr", vif_def.o_vga_addr, 0);
          chk("dis sm addr", vif_sm.o_vga_addr, 0);
        end
        2: chk("dis def blank j2", vif_def.o_blank_n, 1);
        3: chk("dis def blank j3", vif_def.o_blank_n, 0);
        12: begin
          chk("dis def blank", vif_def.o_blank_n, 0);
          chk("dis def fs", vif_def.o_frame_start, 0);
          chk("dis def hsync", vif_def.o_hsync, 1);
          chk("dis def addr hold", vif_def.o_vga_addr, 0);
        end
        default: ;
      endcase
    end

    set_en(1'b1);
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) @(negedge clk);
      case (j)
        0: chk("en def addr j0", vif_def.o_vga_addr, 0);
        1: chk("en def addr j1", vif_def.o_vga_addr, 1);
        2: begin
          chk("en def fs j2", vif_def.o_frame_start, 0);
          chk("en sm fs j2", vif_sm.o_frame_start, 1);
        end
        3: begin
          chk("en def fs j3", vif_def.o_frame_start, 1);
          chk("en def blank j3", vif_def.o_blank_n, 1);
        end
        4: chk("en def fs j4", vif_def.o_frame_start, 0);
        20: begin
          chk("pre-rst def addr", vif_def.o_vga_addr, 20);
          chk("pre-rst def blank", vif_def.o_blank_n, 1);
          chk("pre-rst sm addr", vif_sm.o_vga_addr, 13);
          chk("pre-rst sm blank", vif_sm.o_blank_n, 1);
        end
        default: ;
      endcase
    end

    // Asynchronous reset between clock edges.
    #2 rstn = 1'b0;
    #1;
    chk("async def addr",  vif_def.o_vga_addr, 0);
    chk("async def blank", vif_def.o_blank_n, 0);
    chk("async def hsync", vif_def.o_hsync, 1);
    chk("async sm addr",   vif_sm.o_vga_addr, 0);
    chk("async sm blank",  vif_sm.o_blank_n, 0);

    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      case (k)
        0: chk("restart def addr k0", vif_def.o_vga_addr, 0);
        2: chk("restart def fs k2", vif_def.o_frame_start, 0);
        3: chk("restart def fs k3", vif_def.o_frame_start, 1);
        5: chk("restart def addr k5", vif_def.o_vga_addr, 5);
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
